kgp_multicycle_ctrl: RTL and testbench
======================================

// Module: kgp_multicycle_ctrl
// PURPOSE
//  Multi-cycle main control FSM for the KGP-RISC core. Sequences fetch, decode, execute, memory and
//  writeback over a single shared memory port. Drives PC/IR/regfile/memory strobes and datapath muxes.
//  The ALU control decoder stays a separate block, fed from the same IR opcode/funct fields.
// PARAMETERS
//  WAIT_LIMIT  255  max cycles a memory request may wait for mem_ready before TRAP (1..255)
//  CNT_W       32   width of retired-instruction counter (only with KGP_INSTR_COUNT_EN)
// PORTS
//  clk          in   1      system clock; all state changes on rising edge
//  rst          in   1      synchronous, active-low reset
//  opcode       in   6      IR[31:26]
//  funct        in   6      IR function field (R-type only)
//  flag_zero    in   1      ALU zero flag (ALUOps 1110 passes A)
//  flag_sign    in   1      ALU sign flag
//  flag_carry   in   1      registered carry flag from last add/comp
//  mem_ready    in   1      memory accepts/completes current request this cycle
//  mem_re       out  1      memory read request (fetch or lw); held until mem_ready
//  mem_we       out  1      memory write request (sw); held until mem_ready
//  mem_addr_sel out  1      0 = PC, 1 = ALU result
//  ir_we        out  1      load IR from memory data
//  pc_we        out  1      PC write enable
//  pc_src       out  2      00 PC+4, 01 PC+imm target, 10 register A
//  alu_src      out  1      0 = register B, 1 = sign-extended immediate
//  reg_we       out  1      register-file write enable
//  wb_sel       out  2      00 ALU, 01 memory data, 10 PC (link, dest = ra)
//  state_o      out  3      current state code (debug)
//  trap         out  1      sticky: illegal instruction or memory timeout
//  instr_count  out  CNT_W  retired instructions (present only with KGP_INSTR_COUNT_EN)
// BEHAVIOUR
//  States: FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 TRAP=7. All outputs 0 in any state unless listed.
//  Reset: rst low at rising edge -> state FETCH, wait counter 0, trap 0. While rst low, all outputs
//    forced 0 combinationally. Reset mid-request abandons it; no strobe is issued in the reset cycle.
//  FETCH: mem_re=1, mem_addr_sel=0. On mem_ready: ir_we=1, pc_we=1, pc_src=00 -> DECODE.
//  DECODE: 1 cycle. Legal opcodes: 000000 R, 001000 addi, 001001 compi, 010000 lw, 011000 sw,
//    101000 b, 100000 br, 101001 bcy, 101010 bncy, 110000 bltz, 110001 bz, 110010 bnz, 101011 bl.
//    R-type legal funct: 000001 000101 000100 000010 000011 001100 001000 001110 001010 001111 001011.
//    Legal -> EXEC. Otherwise -> TRAP.
//  EXEC: alu_src=1 for addi/compi/lw/sw, else 0. R/addi/compi -> WB. lw/sw -> MEM.
//    Branches resolve here and return to FETCH. Taken: pc_we=1.
//    b, bl: always taken, pc_src=01; bl also reg_we=1, wb_sel=10 (link = already-incremented PC).
//    br: taken, pc_src=10. bcy: flag_carry. bncy: !flag_carry. bltz: flag_sign. bz: flag_zero.
//    bnz: !flag_zero. Conditional branches use pc_src=01.
//  MEM: mem_addr_sel=1. lw: mem_re=1; on mem_ready -> WB with data latched externally.
//    sw: mem_we=1; on mem_ready -> FETCH (retire).
//  WB: reg_we=1; wb_sel=01 for lw, 00 otherwise -> FETCH.
//  Memory wait: 8-bit counter cleared on entry to FETCH/MEM; increments each cycle mem_ready=0.
//    Reaching WAIT_LIMIT -> TRAP. Requests stay stable while waiting.
//    mem_ready in a cycle with no request is ignored.
//  TRAP: trap=1, no strobes, PC frozen; exit only via reset.
//  Latency, zero-wait memory: ALU op 4 cycles, lw 5, sw 4, branch 3.
//  Retire point: WB exit, sw MEM exit, or any branch EXEC cycle.
// CONFIGURATION
//  KGP_INSTR_COUNT_EN defined: instr_count port exists. Reset 0; +1 per retire; wraps at 2^CNT_W.
//    Not incremented in TRAP.
//  KGP_INSTR_COUNT_EN undefined: port and counter absent. All other behaviour identical.
// TESTING
//  Reset, mem_ready=1, addi fetched -> state 0,1,2,4,0; reg_we=1 only in the WB cycle; alu_src=1 in EXEC.
//  lw, mem_ready low 3 cycles in MEM -> mem_re, mem_addr_sel held 4 cycles; then WB with wb_sel=01.
//  bz: flag_zero=1 -> pc_we=1, pc_src=01 in EXEC. flag_zero=0 -> pc_we=0. Each returns to FETCH after 3 cycles.
//  bl -> one EXEC cycle with pc_we=1, reg_we=1, wb_sel=10. br -> pc_src=10.
//  opcode 111111, or R-type funct 000000 -> TRAP, trap=1 sticky; rst=0 one edge -> FETCH, trap=0.
//  mem_ready stuck 0 in FETCH, WAIT_LIMIT=4 -> TRAP after 4 wait cycles.
//    With KGP_INSTR_COUNT_EN, 3 retires then trap -> instr_count=3.

Source files
------------

// File: rtl/kgp_multicycle_ctrl_if.sv
// Controller <-> datapath/memory signal bundle for kgp_multicycle_ctrl.
// instr_count is present only when KGP_INSTR_COUNT_EN is defined.
interface kgp_multicycle_ctrl_if #(
   parameter int unsigned CNT_W = 32
);
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       flag_zero;
   logic       flag_sign;
   logic       flag_carry;
   logic       mem_ready;
   logic       mem_re;
   logic       mem_we;
   logic       mem_addr_sel;
   logic       ir_we;
   logic       pc_we;
   logic [1:0] pc_src;
   logic       alu_src;
   logic       reg_we;
   logic [1:0] wb_sel;
   logic [2:0] state_o;
   logic       trap;
`ifdef KGP_INSTR_COUNT_EN
   logic [CNT_W-1:0] instr_count;

   modport master (
      input  opcode, funct, flag_zero, flag_sign, flag_carry, mem_ready,
      output mem_re, mem_we, mem_addr_sel, ir_we, pc_we, pc_src, alu_src,
             reg_we, wb_sel, state_o, trap, instr_count
   );
   modport slave (
      output opcode, funct, flag_zero, flag_sign, flag_carry, mem_ready,
      input  mem_re, mem_we, mem_addr_sel, ir_we, pc_we, pc_src, alu_src,
             reg_we, wb_sel, state_o, trap, instr_count
   );
`else
   modport master (
      input  opcode, funct, flag_zero, flag_sign, flag_carry, mem_ready,
      output mem_re, mem_we, mem_addr_sel, ir_we, pc_we, pc_src, alu_src,
             reg_we, wb_sel, state_o, trap
   );
   modport slave (
      output opcode, funct, flag_zero, flag_sign, flag_carry, mem_ready,
      input  mem_re, mem_we, mem_addr_sel, ir_we, pc_we, pc_src, alu_src,
             reg_we, wb_sel, state_o, trap
   );
`endif
endinterface

// File: rtl/kgp_multicycle_ctrl.sv
// KGP-RISC multi-cycle main control FSM sequencing fetch/decode/exec/mem/wb over one memory port.
// Optional retired-instruction counter is built only when KGP_INSTR_COUNT_EN is defined.
module kgp_multicycle_ctrl #(
   parameter int unsigned WAIT_LIMIT = 255,
   parameter int unsigned CNT_W      = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   kgp_multicycle_ctrl_if.master bus
);
   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd7
   } state_t;

   localparam logic [5:0] OP_R     = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_COMPI = 6'b001001;
   localparam logic [5:0] OP_LW    = 6'b010000;
   localparam logic [5:0] OP_SW    = 6'b011000;
   localparam logic [5:0] OP_B     = 6'b101000;
   localparam logic [5:0] OP_BR    = 6'b100000;
   localparam logic [5:0] OP_BCY   = 6'b101001;
   localparam logic [5:0] OP_BNCY  = 6'b101010;
   localparam logic [5:0] OP_BLTZ  = 6'b110000;
   localparam logic [5:0] OP_BZ    = 6'b110001;
   localparam logic [5:0] OP_BNZ   = 6'b110010;
   localparam logic [5:0] OP_BL    = 6'b101011;
   localparam logic [7:0] WAIT_MAX = 8'(WAIT_LIMIT);

   state_t     state_q, state_d;
   logic [7:0] wait_q, wait_d;
   logic       is_lw, is_sw, is_imm, is_branch, legal, br_take;

   always_comb begin
      is_lw     = (bus.opcode == OP_LW);
      is_sw     = (bus.opcode == OP_SW);
      is_imm    = bus.opcode inside {OP_ADDI, OP_COMPI, OP_LW, OP_SW};
      is_branch = bus.opcode inside {OP_B, OP_BR, OP_BCY, OP_BNCY, OP_BLTZ, OP_BZ, OP_BNZ, OP_BL};
      if (bus.opcode == OP_R)
         legal = bus.funct inside {6'b000001, 6'b000101, 6'b000100, 6'b000010, 6'b000011,
                                   6'b001100, 6'b001000, 6'b001110, 6'b001010, 6'b001111,
                                   6'b001011};
      else
         legal = is_imm || is_branch;
      case (bus.opcode)
         OP_B, OP_BL, OP_BR: br_take = 1'b1;
         OP_BCY:             br_take = bus.flag_carry;
         OP_BNCY:            br_take = !bus.flag_carry;
         OP_BLTZ:            br_take = bus.flag_sign;
         OP_BZ:              br_take = bus.flag_zero;
         OP_BNZ:             br_take = !bus.flag_zero;
         default:            br_take = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_FETCH;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
      end
   end

   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      case (state_q)
         S_FETCH, S_MEM: begin
            if (bus.mem_ready) begin
               if (state_q == S_FETCH) state_d = S_DECODE;
               else                    state_d = is_lw ? S_WB : S_FETCH;
            end else if (wait_q + 8'd1 >= WAIT_MAX) begin
               state_d = S_TRAP;
            end else begin
               wait_d = wait_q + 8'd1;
            end
         end
         S_DECODE: state_d = legal ? S_EXEC : S_TRAP;
         S_EXEC: begin
            if (is_lw || is_sw)  state_d = S_MEM;
            else if (is_branch)  state_d = S_FETCH;
            else                 state_d = S_WB;
         end
         S_WB:    state_d = S_FETCH;
         default: state_d = S_TRAP;
      endcase
      // Every state change clears the counter, so FETCH and MEM always start from zero.
      if (state_d != state_q) wait_d = '0;
   end

   always_comb begin
      bus.mem_re       = 1'b0;
      bus.mem_we       = 1'b0;
      bus.mem_addr_sel = 1'b0;
      bus.ir_we        = 1'b0;
      bus.pc_we        = 1'b0;
      bus.pc_src       = 2'b00;
      bus.alu_src      = 1'b0;
      bus.reg_we       = 1'b0;
      bus.wb_sel       = 2'b00;
      bus.state_o      = 3'd0;
      bus.trap         = 1'b0;
      if (rst) begin
         bus.state_o = state_q;
         case (state_q)
            S_FETCH: begin
               bus.mem_re = 1'b1;
               bus.ir_we  = bus.mem_ready;
               bus.pc_we  = bus.mem_ready;
            end
            S_EXEC: begin
               bus.alu_src = is_imm;
               bus.pc_we   = br_take;
               if (br_take) bus.pc_src = (bus.opcode == OP_BR) ? 2'b10 : 2'b01;
               if (bus.opcode == OP_BL) begin
                  bus.reg_we = 1'b1;
                  bus.wb_sel = 2'b10;
               end
            end
            S_MEM: begin
               bus.mem_addr_sel = 1'b1;
               bus.mem_re       = is_lw;
               bus.mem_we       = is_sw;
            end
            S_WB: begin
               bus.reg_we = 1'b1;
               bus.wb_sel = is_lw ? 2'b01 : 2'b00;
            end
            S_TRAP:  bus.trap = 1'b1;
            default: ;
         endcase
      end
   end

`ifdef KGP_INSTR_COUNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             retire;

   always_comb begin
      retire = (state_q == S_WB) || (state_q == S_EXEC && is_branch) ||
               (state_q == S_MEM && is_sw && bus.mem_ready);
      cnt_d  = retire ? cnt_q + 1'b1 : cnt_q;
   end

   always_ff @(posedge clk) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end

   assign bus.instr_count = rst ? cnt_q : '0;
`endif
endmodule

// File: tb/tb_kgp_multicycle_ctrl.sv
// Scoreboard bench for kgp_multicycle_ctrl: per-cycle expected output vectors queued with stimulus.
module tb_kgp_multicycle_ctrl;
   localparam int unsigned WAIT_LIMIT = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_assert = 0;
   int   n_fail   = 0;

   kgp_multicycle_ctrl_if #(.CNT_W(32)) bus ();
   kgp_multicycle_ctrl #(.WAIT_LIMIT(WAIT_LIMIT), .CNT_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Step: per-cycle stimulus plus the output vector required in that cycle.
   typedef struct packed {
      logic [5:0]  op;
      logic [5:0]  fn;
      logic [2:0]  flg;   // {zero, sign, carry}
      logic        rdy;
      logic [14:0] e;
   } step_t;
   step_t sb[$];

   localparam logic [5:0] ADDI = 6'b001000, COMPI = 6'b001001, LW = 6'b010000, SW = 6'b011000;
   localparam logic [5:0] RT = 6'b000000, BOP = 6'b101000;

   // {state, trap, mem_re, mem_we, mem_addr_sel, ir_we, pc_we, pc_src, alu_src, reg_we, wb_sel}
   function automatic logic [14:0] obs();
      return {bus.state_o, bus.trap, bus.mem_re, bus.mem_we, bus.mem_addr_sel, bus.ir_we,
              bus.pc_we, bus.pc_src, bus.alu_src, bus.reg_we, bus.wb_sel};
   endfunction

   function automatic logic [14:0] e_fetch(input logic r);
      return {3'd0, 1'b0, 1'b1, 1'b0, 1'b0, r, r, 2'b00, 1'b0, 1'b0, 2'b00};
   endfunction
   function automatic logic [14:0] e_dec();
      return {3'd1, 12'd0};
   endfunction
   function automatic logic [14:0] e_exec(input logic als);
      return {3'd2, 6'd0, 2'b00, als, 1'b0, 2'b00};
   endfunction
   function automatic logic [14:0] e_mem(input logic lw);
      return {3'd3, 1'b0, lw, ~lw, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00};
   endfunction
   function automatic logic [14:0] e_wb(input logic [1:0] wbs);
      return {3'd4, 9'd0, 1'b1, wbs};
   endfunction
   function automatic logic [14:0] e_br(input logic tk, input logic [1:0] pcs, input logic link);
      return {3'd2, 5'd0, tk, pcs, 1'b0, link, (link ? 2'b10 : 2'b00)};
   endfunction
   function automatic logic [14:0] e_trap();
      return {3'd7, 1'b1, 11'd0};
   endfunction

   task automatic push(input logic [5:0] op, input logic [5:0] fn, input logic [2:0] flg,
                       input logic rdy, input logic [14:0] e);
      step_t s;
      s.op = op; s.fn = fn; s.flg = flg; s.rdy = rdy; s.e = e;
      sb.push_back(s);
   endtask

   task automatic seq_fetch(input logic [5:0] op, input logic [5:0] fn, input int waits);
      for (int i = 0; i < waits; i++) push(op, fn, 3'b000, 1'b0, e_fetch(1'b0));
      push(op, fn, 3'b000, 1'b1, e_fetch(1'b1));
      push(op, fn, 3'b000, 1'b1, e_dec());
   endtask

   task automatic seq_alu(input logic [5:0] op, input logic [5:0] fn, input logic als);
      seq_fetch(op, fn, 0);
      push(op, fn, 3'b000, 1'b1, e_exec(als));
      push(op, fn, 3'b000, 1'b1, e_wb(2'b00));
   endtask

   task automatic seq_mem(input logic [5:0] op, input int fwaits, input int mwaits);
      seq_fetch(op, 6'd0, fwaits);
      push(op, 6'd0, 3'b000, 1'b1, e_exec(1'b1));
      for (int i = 0; i < mwaits; i++) push(op, 6'd0, 3'b000, 1'b0, e_mem(op == LW));
      push(op, 6'd0, 3'b000, 1'b1, e_mem(op == LW));
      if (op == LW) push(op, 6'd0, 3'b000, 1'b1, e_wb(2'b01));
   endtask

   // Leaves the bench at the start of the first FETCH cycle after reset.
   task automatic do_reset();
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
   endtask

   task automatic test_reset();
      step_t s;
      int    k = 0;
      bus.flag_zero = 1'b0; bus.flag_sign = 1'b0; bus.flag_carry = 1'b0;
      rst = 1'b0;
      push(ADDI, 6'd0, 3'b000, 1'b1, 15'd0);
      push(ADDI, 6'd0, 3'b000, 1'b1, 15'd0);
      while (sb.size() > 0) begin
         s = sb.pop_front();
         bus.opcode = s.op; bus.funct = s.fn; bus.mem_ready = s.rdy;
         @(negedge clk);
         n_assert++;
         if (obs() !== s.e) begin
            n_fail++;
            $display("FAIL reset_outputs step %0d: observed %h required %h", k, obs(), s.e);
         end
         k++;
         @(posedge clk); #1;
      end
      rst = 1'b1;
   endtask

   task automatic test_alu_ops();
      step_t s;
      int    k = 0;
      seq_alu(ADDI, 6'd0, 1'b1);
      seq_alu(RT, 6'b000001, 1'b0);
      seq_alu(COMPI, 6'd0, 1'b1);
      seq_alu(RT, 6'b001111, 1'b0);
      while (sb.size() > 0) begin
         s = sb.pop_front();
         bus.opcode = s.op; bus.funct = s.fn; bus.mem_ready = s.rdy;
         {bus.flag_zero, bus.flag_sign, bus.flag_carry} = s.flg;
         @(negedge clk);
         n_assert++;
         if (obs() !== s.e) begin
            n_fail++;
            $display("FAIL alu_ops step %0d: observed %h required %h", k, obs(), s.e);
         end
         k++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_mem_waits();
      step_t s;
      int    k = 0;
      seq_mem(LW, WAIT_LIMIT - 1, WAIT_LIMIT - 1);
      seq_mem(SW, 0, 1);
      seq_mem(LW, 0, 0);
      while (sb.size() > 0) begin
         s = sb.pop_front();
         bus.opcode = s.op; bus.funct = s.fn; bus.mem_ready = s.rdy;
         {bus.flag_zero, bus.flag_sign, bus.flag_carry} = s.flg;
         @(negedge clk);
         n_assert++;
         if (obs() !== s.e) begin
            n_fail++;
            $display("FAIL mem_waits step %0d: observed %h required %h", k, obs(), s.e);
         end
         k++;
         @(posedge clk); #1;
      end
   endtask

   typedef struct packed {
      logic [5:0] op;
      logic [2:0] flg;
      logic       tk;
      logic [1:0] pcs;
      logic       link;
   } br_t;

   task automatic test_branches();
      step_t s;
      br_t   tbl[13];
      int    k = 0;
      tbl[0]  = '{6'b101000, 3'b000, 1'b1, 2'b01, 1'b0};
      tbl[1]  = '{6'b100000, 3'b000, 1'b1, 2'b10, 1'b0};
      tbl[2]  = '{6'b101011, 3'b000, 1'b1, 2'b01, 1'b1};
      tbl[3]  = '{6'b101001, 3'b001, 1'b1, 2'b01, 1'b0};
      tbl[4]  = '{6'b101001, 3'b110, 1'b0, 2'b00, 1'b0};
      tbl[5]  = '{6'b101010, 3'b000, 1'b1, 2'b01, 1'b0};
      tbl[6]  = '{6'b101010, 3'b111, 1'b0, 2'b00, 1'b0};
      tbl[7]  = '{6'b110000, 3'b010, 1'b1, 2'b01, 1'b0};
      tbl[8]  = '{6'b110000, 3'b101, 1'b0, 2'b00, 1'b0};
      tbl[9]  = '{6'b110001, 3'b100, 1'b1, 2'b01, 1'b0};
      tbl[10] = '{6'b110001, 3'b011, 1'b0, 2'b00, 1'b0};
      tbl[11] = '{6'b110010, 3'b011, 1'b1, 2'b01, 1'b0};
      tbl[12] = '{6'b110010, 3'b100, 1'b0, 2'b00, 1'b0};
      for (int i = 0; i < 13; i++) begin
         push(tbl[i].op, 6'd0, tbl[i].flg, 1'b1, e_fetch(1'b1));
         push(tbl[i].op, 6'd0, tbl[i].flg, 1'b1, e_dec());
         push(tbl[i].op, 6'd0, tbl[i].flg, 1'b1, e_br(tbl[i].tk, tbl[i].pcs, tbl[i].link));
      end
      while (sb.size() > 0) begin
         s = sb.pop_front();
         bus.opcode = s.op; bus.funct = s.fn; bus.mem_ready = s.rdy;
         {bus.flag_zero, bus.flag_sign, bus.flag_carry} = s.flg;
         @(negedge clk);
         n_assert++;
         if (obs() !== s.e) begin
            n_fail++;
            $display("FAIL branch step %0d op %b: observed %h required %h", k, s.op, obs(), s.e);
         end
         k++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_illegal();
      step_t s;
      int    k = 0;
      for (int pass = 0; pass < 2; pass++) begin
         if (pass == 0) seq_fetch(6'b111111, 6'd0, 0);
         else           seq_fetch(RT, 6'b000000, 0);
         for (int i = 0; i < 3; i++) push(ADDI, 6'd0, 3'b111, 1'b1, e_trap());
         while (sb.size() > 0) begin
            s = sb.pop_front();
            bus.opcode = s.op; bus.funct = s.fn; bus.mem_ready = s.rdy;
            {bus.flag_zero, bus.flag_sign, bus.flag_carry} = s.flg;
            @(negedge clk);
            n_assert++;
            if (obs() !== s.e) begin
               n_fail++;
               $display("FAIL illegal pass %0d step %0d: observed %h required %h", pass, k, obs(), s.e);
            end
            k++;
            @(posedge clk); #1;
         end
         rst = 1'b0;
         @(negedge clk);
         n_assert++;
         if (obs() !== 15'd0) begin
            n_fail++;
            $display("FAIL trap_reset_forced pass %0d: observed %h required %h", pass, obs(), 15'd0);
         end
         @(posedge clk); #1;
         rst = 1'b1;
      end
   endtask

   task automatic test_timeout();
      step_t s;
      int    k = 0;
      for (int i = 0; i < int'(WAIT_LIMIT); i++) push(ADDI, 6'd0, 3'b000, 1'b0, e_fetch(1'b0));
      push(ADDI, 6'd0, 3'b000, 1'b1, e_trap());
      push(ADDI, 6'd0, 3'b000, 1'b1, e_trap());
      while (sb.size() > 0) begin
         s = sb.pop_front();
         bus.opcode = s.op; bus.funct = s.fn; bus.mem_ready = s.rdy;
         {bus.flag_zero, bus.flag_sign, bus.flag_carry} = s.flg;
         @(negedge clk);
         n_assert++;
         if (obs() !== s.e) begin
            n_fail++;
            $display("FAIL timeout step %0d: observed %h required %h", k, obs(), s.e);
         end
         k++;
         @(posedge clk); #1;
      end
      do_reset();
   endtask

`ifdef KGP_INSTR_COUNT_EN
   task automatic test_instr_count();
      step_t s;
      int    k = 0;
      do_reset();
      @(negedge clk);
      n_assert++;
      if (bus.instr_count !== 32'd0) begin
         n_fail++;
         $display("FAIL instr_count_reset: observed %0d required 0", bus.instr_count);
      end
      @(posedge clk); #1;
      do_reset();
      seq_alu(ADDI, 6'd0, 1'b1);
      seq_mem(SW, 0, 0);
      seq_fetch(BOP, 6'd0, 0);
      push(BOP, 6'd0, 3'b000, 1'b1, e_br(1'b1, 2'b01, 1'b0));
      for (int i = 0; i < int'(WAIT_LIMIT); i++) push(ADDI, 6'd0, 3'b000, 1'b0, e_fetch(1'b0));
      push(ADDI, 6'd0, 3'b000, 1'b1, e_trap());
      push(ADDI, 6'd0, 3'b000, 1'b1, e_trap());
      while (sb.size() > 0) begin
         s = sb.pop_front();
         bus.opcode = s.op; bus.funct = s.fn; bus.mem_ready = s.rdy;
         {bus.flag_zero, bus.flag_sign, bus.flag_carry} = s.flg;
         @(negedge clk);
         n_assert++;
         if (obs() !== s.e) begin
            n_fail++;
            $display("FAIL instr_count_seq step %0d: observed %h required %h", k, obs(), s.e);
         end
         k++;
         @(posedge clk); #1;
      end
      @(negedge clk);
      n_assert++;
      if (bus.instr_count !== 32'd3) begin
         n_fail++;
         $display("FAIL instr_count_final: observed %0d required 3", bus.instr_count);
      end
      @(posedge clk); #1;
      do_reset();
   endtask
`endif

   initial begin
      bus.opcode = 6'd0; bus.funct = 6'd0; bus.mem_ready = 1'b0;
      bus.flag_zero = 1'b0; bus.flag_sign = 1'b0; bus.flag_carry = 1'b0;
      test_reset();
      test_alu_ops();
      test_mem_waits();
      test_branches();
      test_illegal();
      test_timeout();
`ifdef KGP_INSTR_COUNT_EN
      test_instr_count();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
